// File: rtl/pattern_pkg.sv
// Shared types for the serial pattern path: serializer FSM states and default word width.
package pattern_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: first bit on val_o the cycle after acceptance, WIDTH data cycles per word.
// Backpressure: ready_o only in IDLE or on the last bit, so back-to-back words stream with no gap.
module bit_serializer
   import pattern_pkg::*;
#(
   parameter int   WIDTH      = DEFAULT_WIDTH,
   parameter bit   MSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             val_o,
   output logic             busy_o,
   output logic             last_o
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [CNT_W-1:0] cnt_q;
   logic             val_q;
   logic             busy_q;
   logic             last_q;
   logic             accept;

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   assign ready_o = (state_q == IDLE) || last_q;
   assign accept  = valid_i && ready_o;

   // The register is kept aligned so its head bit is always the one on val_o.
   assign shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         val_q   <= IDLE_LEVEL;
         busy_q  <= 1'b0;
         last_q  <= 1'b0;
      end else if (accept) begin
         state_q <= SHIFT;
         shreg_q <= data_i;
         cnt_q   <= '0;
         val_q   <= head_bit(data_i);
         busy_q  <= 1'b1;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            SHIFT: begin
               if (last_q) begin
                  state_q <= IDLE;
                  val_q   <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  last_q  <= 1'b0;
               end else begin
                  shreg_q <= shreg_d;
                  cnt_q   <= cnt_q + 1'b1;
                  val_q   <= head_bit(shreg_d);
                  last_q  <= (cnt_q == CNT_LAST - 1'b1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign val_o  = val_q;
   assign busy_o = busy_q;
   assign last_o = last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed and random checks of bit_serializer against a word-level reference model.
module tb_bit_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o, val_o, busy_o, last_o;
   logic [3:0] data4_i;
   logic       valid4_i;
   logic       ready4_o, val4_o, busy4_o, last4_o;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .val_o(val_o), .busy_o(busy_o), .last_o(last_o)
   );

   bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut4 (
      .clk(clk), .rst(rst), .data_i(data4_i), .valid_i(valid4_i),
      .ready_o(ready4_o), .val_o(val4_o), .busy_o(busy4_o), .last_o(last4_o)
   );

   int         errors = 0;
   int         checks = 0;
   bit         col_en = 1'b0;
   int         nb = 0;
   int         stray = 0;
   int         framebad = 0;
   logic [7:0] cur;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       exp_q[$];
   logic       seen_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample; the deserializer frames every 8 busy cycles into a word.
   task automatic step();
      @(posedge clk);
      #1;
      if (col_en) begin
         if (busy_o) begin
            if (last_o !== (nb == 7)) framebad++;
            cur[nb[2:0]] = val_o;
            nb++;
            if (nb == 8) begin
               rx_q.push_back(cur);
               nb = 0;
            end
         end else if (val_o !== 1'b0 || last_o !== 1'b0) begin
            stray++;
         end
      end
   endtask

   task automatic push_word_lsb(input logic [7:0] w);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
   endtask

   initial begin
      int n101;
      int sent;
      int cyc;
      logic [7:0] w;

      rst = 1'b1; valid_i = 1'b0; data_i = 8'h00; valid4_i = 1'b0; data4_i = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", ready_o, 1); chk("rst_val", val_o, 0);
      chk("rst_busy", busy_o, 0);   chk("rst_last", last_o, 0);
      chk("rst_val4", val4_o, 1);   chk("rst_ready4", ready4_o, 1);
      rst = 1'b0;
      step();

      // Single word 0x05, plus a window detector for "101" over the observed line.
      exp_q.delete(); push_word_lsb(8'h05);
      seen_q.delete(); seen_q.push_back(val_o);
      data_i = 8'h05; valid_i = 1'b1;
      chk("w05_ready_idle", ready_o, 1);
      step();
      valid_i = 1'b0; data_i = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("w05_bit%0d", i), val_o, exp_q[i]);
         chk($sformatf("w05_busy%0d", i), busy_o, 1);
         chk($sformatf("w05_last%0d", i), last_o, (i == 7));
         seen_q.push_back(val_o);
         step();
      end
      chk("w05_idle_val", val_o, 0);
      chk("w05_idle_busy", busy_o, 0);
      seen_q.push_back(val_o);
      step();
      seen_q.push_back(val_o);
      n101 = 0;
      for (int i = 0; i + 2 < seen_q.size(); i++)
         if (seen_q[i] && !seen_q[i+1] && seen_q[i+2]) n101++;
      chk("w05_match101", n101, 1);

      // Back-to-back 0xA5, 0x3C with junk on data_i between accepting edges.
      exp_q.delete(); push_word_lsb(8'hA5); push_word_lsb(8'h3C);
      data_i = 8'hA5; valid_i = 1'b1;
      step();
      for (int c = 1; c <= 16; c++) begin
         data_i = (c == 8) ? 8'h3C : 8'($urandom);
         if (c == 16) valid_i = 1'b0;
         chk($sformatf("b2b_bit%0d", c), val_o, exp_q[c-1]);
         chk($sformatf("b2b_busy%0d", c), busy_o, 1);
         chk($sformatf("b2b_ready%0d", c), ready_o, (c == 8 || c == 16));
         step();
      end
      chk("b2b_end_busy", busy_o, 0);
      chk("b2b_end_val", val_o, 0);

      // Word 0x00 with 0xFF offered while not ready: must be ignored.
      data_i = 8'h00; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c >= 2 && c <= 6) begin valid_i = 1'b1; data_i = 8'hFF; end
         else valid_i = 1'b0;
         chk($sformatf("ign_bit%0d", c), val_o, 0);
         chk($sformatf("ign_ready%0d", c), ready_o, (c == 8));
         step();
      end
      chk("ign_end_busy", busy_o, 0);
      step();
      chk("ign_still_idle", busy_o, 0);

      // Reset during the 4th bit of 0xFF, then a fresh 0x01.
      data_i = 8'hFF; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      repeat (3) step();
      chk("rstmid_bit4", val_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_val", val_o, 0);  chk("rstmid_busy", busy_o, 0);
      chk("rstmid_last", last_o, 0); chk("rstmid_ready", ready_o, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete(); push_word_lsb(8'h01);
      data_i = 8'h01; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("post_rst_bit%0d", i), val_o, exp_q[i]);
         step();
      end
      chk("post_rst_idle", busy_o, 0);

      // MSB-first, WIDTH=4, idle level 1.
      data4_i = 4'h8; valid4_i = 1'b1;
      step();
      valid4_i = 1'b0; data4_i = 4'h7;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("msb_bit%0d", i), val4_o, (i == 0));
         chk($sformatf("msb_last%0d", i), last4_o, (i == 3));
         chk($sformatf("msb_busy%0d", i), busy4_o, 1);
         step();
      end
      chk("msb_idle_val", val4_o, 1);
      chk("msb_idle_busy", busy4_o, 0);

      // Random stream of 200 words with random valid gaps.
      tx_q.delete(); rx_q.delete(); nb = 0; stray = 0; framebad = 0;
      col_en = 1'b1;
      sent = 0; cyc = 0;
      while (sent < 200 && cyc < 6000) begin
         valid_i = ($urandom_range(0, 3) != 0);
         data_i  = 8'($urandom);
         if (valid_i && ready_o) begin
            tx_q.push_back(data_i);
            sent++;
         end
         step();
         cyc++;
      end
      chk("rand_sent_in_budget", sent, 200);
      valid_i = 1'b0;
      repeat (12) step();
      col_en = 1'b0;
      chk("rand_rx_count", rx_q.size(), tx_q.size());
      for (int i = 0; i < tx_q.size() && i < rx_q.size(); i++) begin
         w = tx_q[i];
         chk($sformatf("rand_word%0d", i), rx_q[i], w);
      end
      chk("rand_stray_outside_busy", stray, 0);
      chk("rand_last_framing", framebad, 0);
      chk("rand_partial_bits", nb, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Upstream stage. Converts parallel words into a one-bit-per-clock serial stream that drives the val_i input of the pattern detector.

Interface
REQ-001 Parameter WIDTH, default 8, is the number of bits per parallel word; legal values are 2 to 32.
REQ-002 Parameter MSB_FIRST, default 0: 0 = LSB shifted out first, 1 = MSB shifted out first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, is the value driven on val_o while no word is being shifted.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_i  input  WIDTH  parallel word to serialize.
REQ-007 valid_i  input  1  data_i is valid this cycle.
REQ-008 ready_o  output  1  the block accepts data_i this cycle.
REQ-009 val_o  output  1  serial bit stream, registered; connects to the detector's val_i.
REQ-010 busy_o  output  1  a word is being shifted out (val_o carries data).
REQ-011 last_o  output  1  val_o carries the final bit of the current word.

Function
REQ-012 FSM states are IDLE and SHIFT.
REQ-013 Handshake: a word is accepted on a rising edge where valid_i && ready_o; with no acceptance, data_i is ignored and nothing changes.
REQ-014 ready_o is 1 in IDLE and 1 in SHIFT while last_o=1; it is 0 otherwise.
REQ-015 IDLE: val_o=IDLE_LEVEL, busy_o=0, last_o=0; on acceptance, load the shift register and a bit counter (=0), then go to SHIFT.
REQ-016 Latency: the first bit of an accepted word appears on val_o in the cycle immediately after the accepting edge.
REQ-017 SHIFT: val_o = current head bit (bit 0 if MSB_FIRST=0, bit WIDTH-1 if MSB_FIRST=1); each edge advances the shift register one bit and increments the counter.
REQ-018 last_o = 1 when the counter equals WIDTH-1 in SHIFT.
REQ-019 Exactly WIDTH data cycles per word: no repeated bits, no dropped bits.
REQ-020 At the last-bit edge, acceptance reloads the register with counter=0 and the block stays in SHIFT, so consecutive words stream with zero gap cycles.
REQ-021 At the last-bit edge without acceptance, the next state is IDLE and val_o returns to IDLE_LEVEL in the next cycle.
REQ-022 The counter is $clog2(WIDTH) bits wide, never wraps past WIDTH-1, and holds while in IDLE.
REQ-023 valid_i changing while ready_o=0 has no effect.
REQ-024 data_i is sampled only at the accepting edge.

Reset
REQ-025 While rst=1, asynchronously: state=IDLE, shift register=0, counter=0, val_o=IDLE_LEVEL, busy_o=0, last_o=0, ready_o=1.
REQ-026 Reset mid-word discards the remaining bits; the first post-reset acceptance starts a fresh word.

Structure
REQ-027 A shared package pattern_pkg holds the FSM state enum (IDLE, SHIFT) and the default word-width constant.
REQ-028 No sub-module: a single module containing the FSM, shift register and counter.

Verification
REQ-029 WIDTH=8, MSB_FIRST=0, send 0x05 once -> val_o = 1,0,1,0,0,0,0,0 on the 8 cycles after acceptance, last_o on the 8th cycle, then IDLE_LEVEL; a downstream pattern_101 flags one match.
REQ-030 Back-to-back 0xA5 then 0x3C, valid_i held high -> 16 contiguous data cycles 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; busy_o never drops; ready_o high only on cycles 8 and 16.
REQ-031 valid_i=1 with 0xFF during cycles 2-6 of word 0x00 -> ignored, val_o all 0 for 8 cycles, ready_o=0 during those cycles.
REQ-032 rst pulsed during the 4th bit of 0xFF -> val_o=0 and busy_o=0 immediately; the next word 0x01 yields 1,0,0,0,0,0,0,0.
REQ-033 MSB_FIRST=1, WIDTH=4, word 0x8 -> val_o = 1,0,0,0 with last_o on the 4th cycle.
REQ-034 Random 200-word stream with random valid_i gaps -> the bench deserializer reproduces every word exactly, and no val_o data cycle occurs outside busy_o.
